// File: rtl/regfile_param.sv
// regfile_param: integer register file, program counter and issue scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write-back to reads.
module regfile_param #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int PC_INC = 4,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic              CK_REF,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] RD_REG_OFFSET,
  input  logic [XLEN-1:0]   REG_DATA_IN,
  input  logic [ADDR_W-1:0] RS1_REG_OFFSET,
  input  logic [ADDR_W-1:0] RS2_REG_OFFSET,
  output logic [XLEN-1:0]   RS1_DATA_OUT,
  output logic [XLEN-1:0]   RS2_DATA_OUT,
  input  logic              PC_LOAD,
  input  logic [XLEN-1:0]   PC_LOAD_VAL,
  input  logic              PC_FREEZE,
  output logic [XLEN-1:0]   PC_DATA_OUT,
  input  logic              ISSUE_EN,
  input  logic [ADDR_W-1:0] ISSUE_RD,
  output logic              RS1_BUSY,
  output logic              RS2_BUSY
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [XLEN-1:0] LP_INC = XLEN'(PC_INC);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_pend;
  logic [XLEN-1:0]  r_pc;

  logic             w_wr_ok;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_pend_nxt;
  logic [XLEN-1:0]  w_pc_nxt;
  logic             w_rs1_hit;
  logic             w_rs2_hit;

  assign w_wr_ok = WR_EN && (RD_REG_OFFSET != '0);

`ifdef REGFILE_BYPASS_EN
  // Forward write-back data to a matching read; never while in reset.
  assign w_rs1_hit = w_wr_ok && !RST
                     && (RD_REG_OFFSET == RS1_REG_OFFSET);
  assign w_rs2_hit = w_wr_ok && !RST
                     && (RD_REG_OFFSET == RS2_REG_OFFSET);
`else
  assign w_rs1_hit = 1'b0;
  assign w_rs2_hit = 1'b0;
`endif

  // Register array: x0 is never written so it stays zero.
  always_ff @(posedge CK_REF or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[RD_REG_OFFSET] <= REG_DATA_IN;
    end
  end

  // Scoreboard set/clear masks; a new producer wins over write-back.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (ISSUE_EN && (ISSUE_RD != '0)) begin
      w_set[ISSUE_RD] = 1'b1;
    end
    if (WR_EN) begin
      w_clr[RD_REG_OFFSET] = 1'b1;
    end
    w_pend_nxt = ((r_pend & ~w_clr) | w_set)
                 & ~NREGS'(1);
  end

  // Pending bits, one per architectural register.
  always_ff @(posedge CK_REF or posedge RST) begin
    if (RST) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  // PC next value: load beats freeze beats increment.
  always_comb begin
    w_pc_nxt = r_pc;
    priority case (1'b1)
      PC_LOAD:   w_pc_nxt = PC_LOAD_VAL;
      PC_FREEZE: w_pc_nxt = r_pc;
      default:   w_pc_nxt = r_pc + LP_INC;
    endcase
  end

  // PC register, wraps modulo 2**XLEN.
  always_ff @(posedge CK_REF or posedge RST) begin
    if (RST) begin
      r_pc <= PC_RESET;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  // Combinational read ports with optional forwarding.
  always_comb begin
    RS1_DATA_OUT = '0;
    RS2_DATA_OUT = '0;
    if (w_rs1_hit) begin
      RS1_DATA_OUT = REG_DATA_IN;
    end else if (RS1_REG_OFFSET != '0) begin
      RS1_DATA_OUT = r_regs[RS1_REG_OFFSET];
    end
    if (w_rs2_hit) begin
      RS2_DATA_OUT = REG_DATA_IN;
    end else if (RS2_REG_OFFSET != '0) begin
      RS2_DATA_OUT = r_regs[RS2_REG_OFFSET];
    end
  end

  assign RS1_BUSY    = r_pend[RS1_REG_OFFSET] && !w_rs1_hit;
  assign RS2_BUSY    = r_pend[RS2_REG_OFFSET] && !w_rs2_hit;
  assign PC_DATA_OUT = r_pc;

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed and random checks of regfile_param
// against an array-based reference model.
module tb_regfile_param;

  logic        CK_REF;
  logic        RST;
  logic        WR_EN;
  logic [4:0]  RD_REG_OFFSET;
  logic [31:0] REG_DATA_IN;
  logic [4:0]  RS1_REG_OFFSET;
  logic [4:0]  RS2_REG_OFFSET;
  logic [31:0] RS1_DATA_OUT;
  logic [31:0] RS2_DATA_OUT;
  logic        PC_LOAD;
  logic [31:0] PC_LOAD_VAL;
  logic        PC_FREEZE;
  logic [31:0] PC_DATA_OUT;
  logic        ISSUE_EN;
  logic [4:0]  ISSUE_RD;
  logic        RS1_BUSY;
  logic        RS2_BUSY;

  int n_chk = 0;
  int n_err = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [31:0] m_regs [32];
  bit          m_pend [32];
  logic [31:0] m_pc;

  regfile_param dut (
    .CK_REF(CK_REF), .RST(RST),
    .WR_EN(WR_EN), .RD_REG_OFFSET(RD_REG_OFFSET),
    .REG_DATA_IN(REG_DATA_IN),
    .RS1_REG_OFFSET(RS1_REG_OFFSET),
    .RS2_REG_OFFSET(RS2_REG_OFFSET),
    .RS1_DATA_OUT(RS1_DATA_OUT),
    .RS2_DATA_OUT(RS2_DATA_OUT),
    .PC_LOAD(PC_LOAD), .PC_LOAD_VAL(PC_LOAD_VAL),
    .PC_FREEZE(PC_FREEZE), .PC_DATA_OUT(PC_DATA_OUT),
    .ISSUE_EN(ISSUE_EN), .ISSUE_RD(ISSUE_RD),
    .RS1_BUSY(RS1_BUSY), .RS2_BUSY(RS2_BUSY)
  );

  initial begin
    CK_REF = 1'b0;
    forever #5 CK_REF = ~CK_REF;
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(logic [4:0] rs);
    if (rs == 0) return 32'h0;
    if (BYP && WR_EN && RD_REG_OFFSET == rs) return REG_DATA_IN;
    return m_regs[rs];
  endfunction

  function automatic logic m_busy(logic [4:0] rs);
    if (BYP && WR_EN && rs != 0 && RD_REG_OFFSET == rs) return 1'b0;
    return m_pend[rs];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_pend[i] = 1'b0;
    end
    m_pc = 32'h0;
  endtask

  // Apply the architectural effect of one clock edge.
  task automatic m_edge();
    if (WR_EN && RD_REG_OFFSET != 0) m_regs[RD_REG_OFFSET] = REG_DATA_IN;
    if (WR_EN) m_pend[RD_REG_OFFSET] = 1'b0;
    if (ISSUE_EN && ISSUE_RD != 0) m_pend[ISSUE_RD] = 1'b1;
    if (PC_LOAD) m_pc = PC_LOAD_VAL;
    else if (!PC_FREEZE) m_pc = m_pc + 32'd4;
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".rs1"}, RS1_DATA_OUT, m_read(RS1_REG_OFFSET));
    chk({tag, ".rs2"}, RS2_DATA_OUT, m_read(RS2_REG_OFFSET));
    chk({tag, ".b1"}, {31'b0, RS1_BUSY}, {31'b0, m_busy(RS1_REG_OFFSET)});
    chk({tag, ".b2"}, {31'b0, RS2_BUSY}, {31'b0, m_busy(RS2_REG_OFFSET)});
    chk({tag, ".pc"}, PC_DATA_OUT, m_pc);
  endtask

  task automatic idle();
    WR_EN = 0; RD_REG_OFFSET = 0; REG_DATA_IN = 0;
    PC_LOAD = 0; PC_LOAD_VAL = 0; PC_FREEZE = 0;
    ISSUE_EN = 0; ISSUE_RD = 0;
  endtask

  // Inputs are set just after a falling edge; check, then clock.
  task automatic tick(string tag);
    #1;
    chk_model(tag);
    @(posedge CK_REF);
    m_edge();
    @(negedge CK_REF);
  endtask

  initial begin
    idle();
    RS1_REG_OFFSET = 0; RS2_REG_OFFSET = 0;
    RST = 1'b1;
    m_reset();
    #2;
    chk("rst.pc", PC_DATA_OUT, 32'h0);
    chk("rst.rs1", RS1_DATA_OUT, 32'h0);
    @(negedge CK_REF);
    RST = 1'b0;

    // PC counts 0,4,8,12; reads of several registers are zero.
    for (int i = 0; i < 4; i++) begin
      RS1_REG_OFFSET = 5'(i + 1); RS2_REG_OFFSET = 5'(31 - i);
      #1;
      chk("pcseq", PC_DATA_OUT, 32'(4 * i));
      chk("pcseq.rd", RS1_DATA_OUT | RS2_DATA_OUT, 32'h0);
      tick("pcseq");
    end

    // Write rd=5, read back next cycle; x0 ignores writes.
    WR_EN = 1; RD_REG_OFFSET = 5; REG_DATA_IN = 32'hDEADBEEF;
    tick("w5");
    WR_EN = 1; RD_REG_OFFSET = 0; REG_DATA_IN = 32'h1;
    RS1_REG_OFFSET = 5; RS2_REG_OFFSET = 0;
    #1;
    chk("r5", RS1_DATA_OUT, 32'hDEADBEEF);
    tick("w0");
    #1;
    chk("r0", RS2_DATA_OUT, 32'h0);
    idle();

    // PC wrap, load beats freeze, freeze holds.
    PC_LOAD = 1; PC_LOAD_VAL = 32'hFFFFFFFC;
    tick("ldwrap");
    PC_LOAD = 0;
    #1 chk("pcmax", PC_DATA_OUT, 32'hFFFFFFFC);
    tick("wrap");
    #1 chk("wrap0", PC_DATA_OUT, 32'h0);
    PC_LOAD = 1; PC_FREEZE = 1; PC_LOAD_VAL = 32'h100;
    tick("ldfrz");
    PC_LOAD = 0;
    #1 chk("ld100", PC_DATA_OUT, 32'h100);
    tick("frz");
    #1 chk("hold", PC_DATA_OUT, 32'h100);
    idle();

    // Scoreboard: issue 7, issue+write 7, write 7.
    RS1_REG_OFFSET = 7; RS2_REG_OFFSET = 7;
    ISSUE_EN = 1; ISSUE_RD = 7;
    tick("iss7");
    #1 chk("busy7", {31'b0, RS1_BUSY}, 32'h1);
    WR_EN = 1; RD_REG_OFFSET = 7; REG_DATA_IN = 32'h77;
    tick("isswr7");
    idle();
    #1 chk("still7", {31'b0, RS1_BUSY}, 32'h1);
    WR_EN = 1; RD_REG_OFFSET = 7; REG_DATA_IN = 32'h78;
    tick("wr7");
    idle();
    #1 chk("free7", {31'b0, RS1_BUSY}, 32'h0);
    chk("data7", RS1_DATA_OUT, 32'h78);

    // Same-cycle write and read of a pending register.
    WR_EN = 1; RD_REG_OFFSET = 3; REG_DATA_IN = 32'h11;
    ISSUE_EN = 1; ISSUE_RD = 3;
    tick("prep3");
    idle();
    WR_EN = 1; RD_REG_OFFSET = 3; REG_DATA_IN = 32'h55;
    RS1_REG_OFFSET = 3;
    #1;
    chk("byp.d", RS1_DATA_OUT, BYP ? 32'h55 : 32'h11);
    chk("byp.b", {31'b0, RS1_BUSY}, BYP ? 32'h0 : 32'h1);
    tick("byp");
    idle();

    // Randomized traffic, indices biased low for collisions.
    for (int n = 0; n < 300; n++) begin
      WR_EN = 1'($urandom_range(0, 1));
      RD_REG_OFFSET = 5'($urandom_range(0, 7));
      REG_DATA_IN = $urandom;
      ISSUE_EN = 1'($urandom_range(0, 1));
      ISSUE_RD = 5'($urandom_range(0, 7));
      RS1_REG_OFFSET = 5'($urandom_range(0, 7));
      RS2_REG_OFFSET = ($urandom_range(0, 3) == 0) ?
                       5'($urandom) : 5'($urandom_range(0, 7));
      PC_LOAD = ($urandom_range(0, 7) == 0);
      PC_LOAD_VAL = $urandom;
      PC_FREEZE = ($urandom_range(0, 3) == 0);
      tick("rnd");
    end
    idle();

    // Reset in the middle of a write to a pending register.
    WR_EN = 1; RD_REG_OFFSET = 9; REG_DATA_IN = 32'hAAAA;
    ISSUE_EN = 1; ISSUE_RD = 9;
    tick("prep9");
    WR_EN = 1; RD_REG_OFFSET = 9; REG_DATA_IN = 32'h1234;
    ISSUE_EN = 1; ISSUE_RD = 9;
    PC_LOAD = 1; PC_LOAD_VAL = 32'h500;
    RS1_REG_OFFSET = 9; RS2_REG_OFFSET = 9;
    #2;
    chk("pre.pc", PC_DATA_OUT, m_pc);
    RST = 1'b1;
    #1;
    chk("mr.rs1", RS1_DATA_OUT, 32'h0);
    chk("mr.b1", {31'b0, RS1_BUSY}, 32'h0);
    chk("mr.pc", PC_DATA_OUT, 32'h0);
    @(posedge CK_REF);
    #1;
    chk("mr.edge.rs2", RS2_DATA_OUT, 32'h0);
    chk("mr.edge.b2", {31'b0, RS2_BUSY}, 32'h0);
    chk("mr.edge.pc", PC_DATA_OUT, 32'h0);
    @(negedge CK_REF);
    RST = 1'b0;
    idle();
    m_reset();
    tick("post");
    #1 chk("post.pc", PC_DATA_OUT, 32'h4);
    chk("post.r9", RS1_DATA_OUT, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
